// File: rtl/seg7_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package : seg7_pkg                                               |
// | Shared constants for the seven-segment scan driver: active-high  |
// | hex glyphs {g,f,e,d,c,b,a}, digit count and index helpers.       |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
package seg7_pkg;

  localparam int DIGITS = 8;
  localparam int IDX_W  = 3;

  typedef logic [IDX_W-1:0] idx_t;

  // Active-high glyphs, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0   = 7'h3F;
  localparam logic [6:0] SEG_1   = 7'h06;
  localparam logic [6:0] SEG_2   = 7'h5B;
  localparam logic [6:0] SEG_3   = 7'h4F;
  localparam logic [6:0] SEG_4   = 7'h66;
  localparam logic [6:0] SEG_5   = 7'h6D;
  localparam logic [6:0] SEG_6   = 7'h7D;
  localparam logic [6:0] SEG_7   = 7'h07;
  localparam logic [6:0] SEG_8   = 7'h7F;
  localparam logic [6:0] SEG_9   = 7'h6F;
  localparam logic [6:0] SEG_A   = 7'h77;
  localparam logic [6:0] SEG_B   = 7'h7C;
  localparam logic [6:0] SEG_C   = 7'h39;
  localparam logic [6:0] SEG_D   = 7'h5E;
  localparam logic [6:0] SEG_E   = 7'h79;
  localparam logic [6:0] SEG_F   = 7'h71;
  localparam logic [6:0] SEG_OFF = 7'h00;

  // Index of the most-significant non-zero nibble; 0 for an all-zero word
  function automatic idx_t top_digit(input logic [31:0] w);
    idx_t r;
    r = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (w[4*k +: 4] != 4'h0) r = idx_t'(k);
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hex_to_seg7.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : hex_to_seg7                                            |
// | Combinational nibble to active-high seven-segment glyph decoder. |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  // Map each hex value to its standard glyph
  always_comb begin
    seg = SEG_OFF;
    case (nib)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_OFF;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seg7_scan.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : seg7_scan                                              |
// | Eight-digit multiplexed seven-segment driver for the OUT port    |
// | word, with a decimal-point "fresh" flag on digit 0.              |
// | Optional: define SEG_LZB_EN for leading-zero blanking.           |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int FRESH_FRAMES   = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_i,
  input  logic        load_i,
  output logic [7:0]  an_o,
  output logic [6:0]  seg_o,
  output logic        dp_o
);

  localparam int              DIV_W      = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [7:0]      FRESH_INIT = 8'(FRESH_FRAMES);
  localparam idx_t            IDX_LAST   = idx_t'(DIGITS - 1);

  logic             load_d;
  logic [31:0]      disp_q;
  logic [DIV_W-1:0] div_q;
  idx_t             idx_q;
  logic [7:0]       fresh_q;

  logic             tick;
  logic             frame_end;
  logic [31:0]      disp_next;
  logic [7:0]       fresh_next;
  logic [3:0]       nib;
  logic [6:0]       glyph;
  logic             blank;
  logic [7:0]       an_hi;
  logic [6:0]       seg_hi;
  logic             dp_hi;

  assign tick      = (div_q == DIV_LAST);
  assign frame_end = tick && (idx_q == IDX_LAST);

  // The word arrives one cycle after the strobe; decoding from the
  // next-state value lets a new glyph reach the pins in the same edge
  // that captures it.
  assign disp_next = load_d ? data_i : disp_q;

  // Fresh counter next state: reload beats a coincident frame end
  always_comb begin
    fresh_next = fresh_q;
    if (load_d) begin
      fresh_next = FRESH_INIT;
    end else if (frame_end && (fresh_q != 8'd0)) begin
      fresh_next = fresh_q - 8'd1;
    end
  end

  assign nib = disp_next[{idx_q, 2'b00} +: 4];

  hex_to_seg7 u_dec (
    .nib (nib),
    .seg (glyph)
  );

`ifdef SEG_LZB_EN
  assign blank = (idx_q > top_digit(disp_next));
`else
  assign blank = 1'b0;
`endif

  assign an_hi  = blank ? 8'h00 : (8'h01 << idx_q);
  assign seg_hi = blank ? SEG_OFF : glyph;
  assign dp_hi  = (idx_q == '0) && (fresh_next != 8'd0);

  // Strobe delay and word capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_d <= 1'b0;
      disp_q <= '0;
    end else begin
      load_d <= load_i;
      disp_q <= disp_next;
    end
  end

  // Prescaler and digit index advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
      idx_q <= '0;
    end else if (tick) begin
      div_q <= '0;
      idx_q <= idx_q + 1'b1;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  // Fresh-frame counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fresh_q <= 8'd0;
    end else begin
      fresh_q <= fresh_next;
    end
  end

  // Registered pin drivers with polarity applied; reset blanks the display
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_o  <= {8{SEG_ACTIVE_LOW}};
      seg_o <= {7{SEG_ACTIVE_LOW}};
      dp_o  <= SEG_ACTIVE_LOW;
    end else begin
      an_o  <= an_hi  ^ {8{SEG_ACTIVE_LOW}};
      seg_o <= seg_hi ^ {7{SEG_ACTIVE_LOW}};
      dp_o  <= dp_hi  ^ SEG_ACTIVE_LOW;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : tb_seg7_scan                                           |
// | Self-checking bench for seg7_scan (SCAN_DIV=4, FRESH_FRAMES=2,   |
// | active-low outputs). Honours SEG_LZB_EN when defined.            |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
module tb_seg7_scan;

  localparam int SD    = 4;
  localparam int FRESH = 2;
  localparam int FRAME = 8 * SD;

  logic        clk    = 1'b0;
  logic        rst    = 1'b0;
  logic        load_i = 1'b0;
  logic [31:0] data_i = 32'h0;
  logic [7:0]  an_o;
  logic [6:0]  seg_o;
  logic        dp_o;

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  typedef struct {
    logic [31:0] word;
    logic [55:0] glyphs;   // active-high glyphs {d7..d0}
  } vec_t;

  exp_t sb[$];
  vec_t vecs[4];

  int passed = 0;
  int total  = 0;

  // Reference state
  int          e;
  logic [31:0] m_word;
  logic [55:0] m_glyphs;
  logic [55:0] data_glyphs;
  int          m_fresh;
  logic        m_ld_d;

  seg7_scan #(
    .SCAN_DIV       (SD),
    .FRESH_FRAMES   (FRESH),
    .SEG_ACTIVE_LOW (1'b1)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .data_i (data_i),
    .load_i (load_i),
    .an_o   (an_o),
    .seg_o  (seg_o),
    .dp_o   (dp_o)
  );

  always #5 clk = ~clk;

  function automatic int msd(logic [31:0] w);
    int r;
    r = 0;
    for (int k = 0; k < 8; k++) if (w[4*k +: 4] != 4'h0) r = k;
    return r;
  endfunction

  task automatic check(string nm, exp_t x);
    total++;
    if ({an_o, seg_o, dp_o} !== {x.an, x.seg, x.dp})
      $display("FAIL %s edge=%0d: got an=%h seg=%h dp=%b, want an=%h seg=%h dp=%b",
               nm, e, an_o, seg_o, dp_o, x.an, x.seg, x.dp);
    else
      passed++;
  endtask

  // One clock: advance the reference, push its expectation, compare
  task automatic step();
    exp_t x;
    int   d;
    logic blank;
    @(posedge clk);
    e++;
    if (m_ld_d) begin
      m_word   = data_i;
      m_glyphs = data_glyphs;
      m_fresh  = FRESH;
    end else if ((e % FRAME == 0) && (m_fresh > 0)) begin
      m_fresh--;
    end
    m_ld_d = load_i;
    d      = ((e - 1) / SD) % 8;
    blank  = 1'b0;
`ifdef SEG_LZB_EN
    blank  = (d > msd(m_word));
`endif
    x.an  = blank ? 8'hFF : ~(8'h01 << d);
    x.seg = blank ? 7'h7F : ~m_glyphs[7*d +: 7];
    x.dp  = !((d == 0) && (m_fresh != 0));
    sb.push_back(x);
    #1;
    check("scan", sb.pop_front());
  endtask

  task automatic do_reset();
    #1;
    rst    = 1'b1;
    load_i = 1'b0;
    data_i = 32'h0;
    #1;
    sb.push_back(exp_t'({8'hFF, 7'h7F, 1'b1}));
    check("reset_async", sb.pop_front());
    repeat (2) @(posedge clk);
    #2;
    rst         = 1'b0;
    e           = 0;
    m_word      = 32'h0;
    m_glyphs    = {8{7'h3F}};
    data_glyphs = {8{7'h3F}};
    m_fresh     = 0;
    m_ld_d      = 1'b0;
  endtask

  // Strobe in one cycle, word valid from the next, as the port block does
  task automatic load_vec(logic [31:0] w, logic [55:0] g);
    load_i = 1'b1;
    step();
    load_i      = 1'b0;
    data_i      = w;
    data_glyphs = g;
  endtask

  initial begin
    vecs[0] = '{32'h89ABCDEF, {7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71}};
    vecs[1] = '{32'h00000A05, {7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h77, 7'h3F, 7'h6D}};
    vecs[2] = '{32'h00000000, {8{7'h3F}}};
    vecs[3] = '{32'h76543210, {7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F}};

    // Table-driven: each word scanned for three frames; reset lands mid-frame
    for (int i = 0; i < 4; i++) begin
      do_reset();
      load_vec(vecs[i].word, vecs[i].glyphs);
      repeat (3 * FRAME + 13) step();
    end

    // Release state and load latency
    do_reset();
    load_vec(vecs[0].word, vecs[0].glyphs);
    check("release", exp_t'({8'hFE, 7'h40, 1'b1}));
    step();
    check("load_latency", exp_t'({8'hFE, 7'h0E, 1'b0}));

    // Reload coincident with a frame end keeps the flag for two more frames
    while (e < 30) step();
    load_vec(vecs[0].word, vecs[0].glyphs);
    while (e < 65) step();
    check("fresh_reload_on", exp_t'({8'hFE, 7'h0E, 1'b0}));
    while (e < 97) step();
    check("fresh_expired", exp_t'({8'hFE, 7'h0E, 1'b1}));
    repeat (6) step();

    // Back-to-back strobes: last word wins
    do_reset();
    load_i = 1'b1;
    step();
    data_i      = 32'h1;
    data_glyphs = {{7{7'h3F}}, 7'h06};
    step();
    data_i      = 32'h2;
    data_glyphs = {{7{7'h3F}}, 7'h5B};
    load_i      = 1'b0;
    check("b2b_first", exp_t'({8'hFE, 7'h79, 1'b0}));
    step();
    check("b2b_last", exp_t'({8'hFE, 7'h24, 1'b0}));
    repeat (FRAME) step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seg7_scan.md
# seg7_scan

Eight-digit, time-multiplexed seven-segment driver for the value the CPU publishes with its OUT instruction. It sits directly downstream of the I/O port block. It consumes that block's registered display word (`data_show_o`) and the port's write strobe (`out`). It latches the word on each write and scans its eight hex nibbles onto a common-anode/cathode display. A decimal-point "fresh" flag on digit 0 marks recently updated values.

## Interface
Parameters:
- SCAN_DIV, 50000: clock cycles each digit stays lit; legal range 2..2^20.
- FRESH_FRAMES, 16: number of full 8-digit scan frames the fresh flag stays on after a load; legal range 1..255.
- SEG_ACTIVE_LOW, 1: 1 = `an_o`, `seg_o` and `dp_o` are active-low; 0 = active-high.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; one clock, reset is asynchronous and active-high.
- data_i  in  32  display word from the I/O port (`data_show_o`).
- load_i  in  1  I/O port write strobe (`out`); high for the cycle in which the port register is written.
- an_o  out  8  digit enables; bit k selects digit k, which shows nibble data[4k+3:4k].
- seg_o  out  7  segments {g,f,e,d,c,b,a}.
- dp_o  out  1  decimal point.

## Operation
- Capture:
  - The port updates `data_show_o` on the same edge that samples `out`, so the word is valid one cycle after `load_i`.
  - `load_i` is registered into `load_d`.
  - When `load_d`=1, `data_i` is captured into `disp_q` (32 bits).
  - Back-to-back strobes capture every word; the last one wins.
- Prescaler: `div_q` counts 0..SCAN_DIV-1 and wraps. `tick` is asserted when `div_q`=SCAN_DIV-1.
- Digit index: on `tick`, `idx_q` advances 0→1→…→7→0. `frame_end` = `tick` while `idx_q`=7.
- Fresh counter `fresh_q` (8 bits):
  - Loaded to FRESH_FRAMES when `load_d`=1.
  - Otherwise decremented on `frame_end` when non-zero; saturates at 0.
  - If `load_d` and `frame_end` occur in the same cycle, the load wins.
- Decode: nibble `disp_q[4*idx_q +: 4]` is mapped to standard hex glyphs (0-9, A, b, C, d, E, F), active-high form:
  - 0=0111111, 1=0000110, 8=1111111, A=1110111, F=1110001.
  - The glyphs are inverted when SEG_ACTIVE_LOW=1.
- Decimal point: asserted only while `idx_q`=0 and `fresh_q`≠0.
- Outputs: `an_o`, `seg_o` and `dp_o` are registered from `idx_q`, the decode and the fresh state. Exactly one digit is enabled in any cycle unless blanked (see Configuration).

## Timing
- Reset values:
  - `disp_q`=0, `div_q`=0, `idx_q`=0, `fresh_q`=0, `load_d`=0.
  - All outputs inactive: `an_o`=8'hFF, `seg_o`=7'h7F, `dp_o`=1 when SEG_ACTIVE_LOW=1; all zeros otherwise.
- Reset asserted mid-scan clears all state immediately, asynchronously; the display blanks.
- First rising edge after reset release: digit 0 enabled, showing glyph "0".
- Load latency:
  - `load_i` high in cycle n → `disp_q` updated at the end of cycle n+1.
  - New glyph on the currently lit digit, and `fresh_q` reload, are visible on the outputs in cycle n+2.
- Digit k is lit for exactly SCAN_DIV consecutive cycles. A full frame is 8·SCAN_DIV cycles.
- Output switching between digits occurs in one cycle; no ghost cycle with two digits enabled.

## Configuration
- SEG_LZB_EN defined: leading-zero blanking.
  - Digits above the most-significant non-zero nibble of `disp_q` have `an_o` bit inactive and `seg_o` off while scanned; scan timing is unchanged.
  - Digit 0 is always shown, so a word of 0 displays a single "0".
  - `dp_o` is unaffected by blanking.
- SEG_LZB_EN undefined: all eight digits are always lit in turn, including leading zeros.

## Structure
- Shared package `seg7_pkg`:
  - Active-high glyph constants for 0-F and SEG_OFF.
  - Digit count constant (8) and index width (3).
- Sub-module `hex_to_seg7`: combinational nibble→active-high 7-bit glyph decoder. Polarity inversion and blanking stay in `seg7_scan`.

## Test plan
All scenarios use SCAN_DIV=4, FRESH_FRAMES=2, SEG_ACTIVE_LOW=1.
- Reset:
  - Release → `an_o`=8'hFE, `seg_o`=~7'h3F.
  - Assert rst mid-frame → outputs immediately 8'hFF/7'h7F/1.
- Load 32'h89ABCDEF with `load_i` at cycle n, word valid from n+1:
  - Glyph updates at n+2.
  - Over one frame, digits 0..7 show F,E,d,C,b,A,9,8, each for 4 cycles, with `an_o` walking 8'hFE→8'h7F.
- Fresh flag:
  - After a load, `dp_o`=0 only while digit 0 is lit, for 2 frames, then stays 1.
  - A reload coincident with `frame_end` restores the count to 2.
- Back-to-back `load_i` in cycles n, n+1 with words 32'h1, 32'h2 → `disp_q`=32'h2 at n+3.
- SEG_LZB_EN:
  - 32'h0000_0A05 → digits 3..7 have `an_o` inactive; digits 0..2 show 5,0,A.
  - 32'h0 → only digit 0 lit, showing "0".
- Without SEG_LZB_EN: 32'h0 → all 8 digits show "0" in turn.
